abro_n_detector: RTL

Parametrised N-input ABRO-style event detector. Waits until every one of `N` input lines has been sampled high at least once, in any order and possibly in the same cycle. It then emits a one-cycle `O` pulse and either holds until a soft restart or re-arms automatically. Compared with the fixed two-input block, it adds an optional completion window with timeout abort, a soft `restart` input distinct from `reset`, per-input progress visibility and a saturating completion counter. Sits beside the existing ABRO state-machine blocks in the same single-clock domain.

---
 rtl/abro_n_detector_if.sv | 24 ++
 rtl/abro_n_detector.sv | 121 ++++++++++++
 2 files changed

// File: rtl/abro_n_detector_if.sv
// abro_n_detector handshake bundle.
// Watched lines and soft restart in; progress and pulses out.
interface abro_n_detector_if #(
  parameter int N     = 2,
  parameter int CNT_W = 8
);
  logic [N-1:0]     sig_in;
  logic             restart;
  logic             O;
  logic             timeout;
  logic [N-1:0]     seen;
  logic [1:0]       state;
  logic [CNT_W-1:0] done_count;

  modport master (
    output sig_in, restart,
    input  O, timeout, seen, state, done_count
  );

  modport slave (
    input  sig_in, restart,
    output O, timeout, seen, state, done_count
  );
endinterface

// File: rtl/abro_n_detector.sv
// N-input ABRO event detector with optional completion window,
// soft restart, progress mask and saturating completion counter.
module abro_n_detector #(
  parameter int N          = 2,
  parameter int WINDOW     = 0,
  parameter int AUTO_REARM = 0,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  abro_n_detector_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    ABORT   = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((WINDOW > 0) ? WINDOW - 1 : 0);
  localparam logic [N-1:0]     ALL  = '1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t           r_state, w_state;
  logic [N-1:0]     r_seen, w_seen;
  logic [TW-1:0]    r_timer, w_timer;
  logic             r_o, w_o;
  logic             r_to, w_to;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [N-1:0]     w_acc;
  logic             w_done;

  assign w_acc = r_seen | bus.sig_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_seen  <= '0;
      r_timer <= '0;
      r_o     <= 1'b0;
      r_to    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_seen  <= w_seen;
      r_timer <= w_timer;
      r_o     <= w_o;
      r_to    <= w_to;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_seen  = r_seen;
    w_timer = r_timer;
    w_o     = 1'b0;
    w_to    = 1'b0;
    w_cnt   = r_cnt;
    w_done  = 1'b0;
    if (bus.restart) begin
      w_state = IDLE;
      w_seen  = '0;
      w_timer = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.sig_in == ALL) begin
            w_done = 1'b1;
          end else if (bus.sig_in != '0) begin
            w_state = COLLECT;
            w_seen  = bus.sig_in;
            w_timer = '0;
          end
        end
        COLLECT: begin
          // completion wins over an expiring window
          if (w_acc == ALL) begin
            w_done = 1'b1;
          end else if (WINDOW != 0 && r_timer == TLAST) begin
            w_state = ABORT;
            w_seen  = '0;
            w_timer = '0;
            w_to    = 1'b1;
          end else begin
            w_seen  = w_acc;
            w_timer = r_timer + TW'(1);
          end
        end
        ABORT: begin
          w_state = IDLE;
          w_seen  = '0;
        end
        DONE: begin
          if (AUTO_REARM != 0) begin
            w_state = IDLE;
            w_seen  = '0;
          end
        end
        default: ;
      endcase
    end
    if (w_done) begin
      w_state = DONE;
      w_seen  = ALL;
      w_timer = '0;
      w_o     = 1'b1;
      w_cnt   = (r_cnt == CMAX) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  assign bus.O          = r_o;
  assign bus.timeout    = r_to;
  assign bus.seen       = r_seen;
  assign bus.state      = r_state;
  assign bus.done_count = r_cnt;

endmodule
